// File: rtl/gdd_pkg.sv
// Shared types and sensor-pattern constants for the gate direction detector.
// Patterns are written as {a, b}, where a is the outer beam and b the inner beam.
package gdd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        E1,
        E2,
        E3,
        X1,
        X2,
        X3,
        RECOVER
    } state_t;

    localparam logic [1:0] PAT_NONE = 2'b00;
    localparam logic [1:0] PAT_A    = 2'b10;
    localparam logic [1:0] PAT_BOTH = 2'b11;
    localparam logic [1:0] PAT_B    = 2'b01;

endpackage

// File: rtl/debounce_filter.sv
// 1-bit stability filter: the output follows the input only after CYCLES
// consecutive samples that differ from the current output.
module debounce_filter #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic          q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= 1'b0;
            cnt_q <= '0;
        end else if (d_i == q_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(CYCLES - 1)) begin
            q_q   <= d_i;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/gate_direction_detector.sv
// Two-beam direction detector producing one inc/dec pulse per completed passage.
// Optional per-input debounce filtering is enabled by defining GDD_DEBOUNCE_EN.
module gate_direction_detector
    import gdd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec,
    output logic err,
    output logic busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic                   a_f;
    logic                   b_f;
    logic [1:0]             p;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b};
        end
    end

`ifdef GDD_DEBOUNCE_EN
    debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .d_i   (a_sync_q[SYNC_STAGES-1]),
        .q_o   (a_f)
    );

    debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .d_i   (b_sync_q[SYNC_STAGES-1]),
        .q_o   (b_f)
    );
`else
    assign a_f = a_sync_q[SYNC_STAGES-1];
    assign b_f = b_sync_q[SYNC_STAGES-1];
`endif

    assign p = {a_f, b_f};

    state_t state_q;
    logic   inc_q;
    logic   dec_q;
    logic   err_q;

    // Each state lists only its exits; its own expected pattern falls to the
    // empty default and holds the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RECOVER;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (p)
                        PAT_A:    state_q <= E1;
                        PAT_B:    state_q <= X1;
                        PAT_BOTH: begin state_q <= RECOVER; err_q <= 1'b1; end
                        default:  ;
                    endcase
                end
                E1: begin
                    case (p)
                        PAT_NONE: state_q <= IDLE;
                        PAT_BOTH: state_q <= E2;
                        PAT_B:    begin state_q <= RECOVER; err_q <= 1'b1; end
                        default:  ;
                    endcase
                end
                E2: begin
                    case (p)
                        PAT_A:    state_q <= E1;
                        PAT_B:    state_q <= E3;
                        PAT_NONE: begin state_q <= RECOVER; err_q <= 1'b1; end
                        default:  ;
                    endcase
                end
                E3: begin
                    case (p)
                        PAT_BOTH: state_q <= E2;
                        PAT_NONE: begin state_q <= IDLE; inc_q <= 1'b1; end
                        PAT_A:    begin state_q <= RECOVER; err_q <= 1'b1; end
                        default:  ;
                    endcase
                end
                X1: begin
                    case (p)
                        PAT_NONE: state_q <= IDLE;
                        PAT_BOTH: state_q <= X2;
                        PAT_A:    begin state_q <= RECOVER; err_q <= 1'b1; end
                        default:  ;
                    endcase
                end
                X2: begin
                    case (p)
                        PAT_B:    state_q <= X1;
                        PAT_A:    state_q <= X3;
                        PAT_NONE: begin state_q <= RECOVER; err_q <= 1'b1; end
                        default:  ;
                    endcase
                end
                X3: begin
                    case (p)
                        PAT_BOTH: state_q <= X2;
                        PAT_NONE: begin state_q <= IDLE; dec_q <= 1'b1; end
                        PAT_B:    begin state_q <= RECOVER; err_q <= 1'b1; end
                        default:  ;
                    endcase
                end
                RECOVER: begin
                    if (p == PAT_NONE) state_q <= IDLE;
                end
                default: state_q <= RECOVER;
            endcase
        end
    end

    assign inc  = inc_q;
    assign dec  = dec_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule
